// File: rtl/io_bus_bridge.sv
// rtl/io_bus_bridge.sv - miniRV data-bus responder: DRAM/peripheral decode, LED, 7-seg scan, switch sync, timer
module io_bus_bridge #(
    parameter int SCAN_DIV = 20000,
    parameter int TMR_DIV  = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_we,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PSW = (TMR_DIV > 1) ? $clog2(TMR_DIV) : 1;

    localparam logic [11:0] OFF_DIG = 12'h000;
    localparam logic [11:0] OFF_TMR = 12'h020;
    localparam logic [11:0] OFF_LED = 12'h060;
    localparam logic [11:0] OFF_SW  = 12'h070;
    localparam logic [11:0] OFF_BTN = 12'h078;

    logic [31:0]    dig_q, dig_d;
    logic [31:0]    tmr_q, tmr_d;
    logic [23:0]    led_q, led_d;
    logic [23:0]    sw_s1_q, sw_s2_q;
    logic [4:0]     btn_s1_q, btn_s2_q;
    logic [PSW-1:0] psc_q, psc_d;
    logic [SCW-1:0] sc_q, sc_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     dig_en_q, dig_en_d;
    logic [7:0]     dig_seg_q, dig_seg_d;

    logic        is_periph;
    logic [11:0] offset;
    logic        pwr;
    logic        psc_wrap;
    logic        sc_wrap;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 8'h03;
            4'h1: hex_to_seg = 8'h9F;
            4'h2: hex_to_seg = 8'h25;
            4'h3: hex_to_seg = 8'h0D;
            4'h4: hex_to_seg = 8'h99;
            4'h5: hex_to_seg = 8'h49;
            4'h6: hex_to_seg = 8'h41;
            4'h7: hex_to_seg = 8'h1F;
            4'h8: hex_to_seg = 8'h01;
            4'h9: hex_to_seg = 8'h09;
            4'hA: hex_to_seg = 8'h11;
            4'hB: hex_to_seg = 8'hC1;
            4'hC: hex_to_seg = 8'h63;
            4'hD: hex_to_seg = 8'h85;
            4'hE: hex_to_seg = 8'h61;
            default: hex_to_seg = 8'h71;
        endcase
    endfunction

    assign is_periph  = (Bus_addr[31:12] == 20'hFFFFF);
    assign offset     = Bus_addr[11:0];
    assign pwr        = Bus_wen & is_periph;
    assign dram_we    = Bus_wen & ~is_periph;
    assign dram_addr  = Bus_addr[15:2];
    assign dram_wdata = Bus_wdata;

    always_comb begin
        Bus_rdata = dram_rdata;
        if (is_periph) begin
            case (offset)
                OFF_DIG: Bus_rdata = dig_q;
                OFF_TMR: Bus_rdata = tmr_q;
                OFF_LED: Bus_rdata = {8'b0, led_q};
                OFF_SW:  Bus_rdata = {8'b0, sw_s2_q};
                OFF_BTN: Bus_rdata = {27'b0, btn_s2_q};
                default: Bus_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        dig_d = (pwr && offset == OFF_DIG) ? Bus_wdata : dig_q;
        led_d = (pwr && offset == OFF_LED) ? Bus_wdata[23:0] : led_q;

        // A TMR write both loads the count and restarts the prescale period.
        psc_wrap = (psc_q == PSW'(TMR_DIV - 1));
        psc_d    = psc_wrap ? '0 : psc_q + 1'b1;
        tmr_d    = psc_wrap ? tmr_q + 32'd1 : tmr_q;
        if (pwr && offset == OFF_TMR) begin
            tmr_d = Bus_wdata;
            psc_d = '0;
        end

        sc_wrap = (sc_q == SCW'(SCAN_DIV - 1));
        sc_d    = sc_wrap ? '0 : sc_q + 1'b1;
        idx_d   = sc_wrap ? idx_q + 3'd1 : idx_q;

        // Outputs are registered from next-state so they always match the lit digit.
        dig_en_d  = ~(8'b1 << idx_d);
        dig_seg_d = hex_to_seg(dig_d[{idx_d, 2'b00} +: 4]);
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            dig_q     <= '0;
            tmr_q     <= '0;
            led_q     <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            psc_q     <= '0;
            sc_q      <= '0;
            idx_q     <= '0;
            dig_en_q  <= 8'hFE;
            dig_seg_q <= 8'h03;
        end else begin
            dig_q     <= dig_d;
            tmr_q     <= tmr_d;
            led_q     <= led_d;
            sw_s1_q   <= sw;
            sw_s2_q   <= sw_s1_q;
            btn_s1_q  <= button;
            btn_s2_q  <= btn_s1_q;
            psc_q     <= psc_d;
            sc_q      <= sc_d;
            idx_q     <= idx_d;
            dig_en_q  <= dig_en_d;
            dig_seg_q <= dig_seg_d;
        end
    end

    assign led     = led_q;
    assign dig_en  = dig_en_q;
    assign dig_seg = dig_seg_q;
endmodule

// File: doc/io_bus_bridge.md
Name: io_bus_bridge

Overview:
- Bus-side responder for the miniRV core's data bus (Bus_addr/Bus_wen/Bus_wdata in, Bus_rdata out).
- Sits between myCPU and DRAM. Decodes each access to either DRAM or a memory-mapped peripheral page at 0xFFFF_F000.
- Owns the peripheral state: LED register, 8-digit seven-segment display register with scan FSM, synchronised switch/button inputs, and a prescaled timer counter.

Parameters:
- SCAN_DIV, 20000, cpu_clk cycles each display digit is lit before advancing (min 2).
- TMR_DIV, 1, cpu_clk cycles per timer increment (1 = every cycle).

Ports:
- cpu_clk  in  1  system clock; all state on rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- Bus_addr  in  32  byte address from CPU.
- Bus_wen  in  1  write strobe; write commits on the cpu_clk edge where it is high.
- Bus_wdata  in  32  write data.
- Bus_rdata  out  32  read data, combinational from Bus_addr (same-cycle, as DRAM).
- dram_addr  out  14  word address = Bus_addr[15:2].
- dram_we  out  1  DRAM write enable.
- dram_wdata  out  32  = Bus_wdata.
- dram_rdata  in  32  DRAM async read data.
- sw  in  24  board switches (asynchronous).
- button  in  5  board buttons (asynchronous).
- led  out  24  LED register.
- dig_en  out  8  digit enables, active low, one-hot-zero.
- dig_seg  out  8  segments, active low, bit7..0 = a,b,c,d,e,f,g,dp.

Behaviour:
- Decode:
  - is_periph = (Bus_addr[31:12] == 20'hFFFFF). Otherwise the access goes to DRAM.
  - dram_we = Bus_wen & ~is_periph. Peripheral writes never reach DRAM.
- Peripheral map (offset = Bus_addr[11:0]; other address bits ignored):
  - 0x000 DIG: R/W, 32-bit display value.
  - 0x020 TMR: R/W, timer count.
  - 0x060 LED: R/W, bits [23:0]; reads return zero in [31:24].
  - 0x070 SW: RO, {8'b0, sw_sync}.
  - 0x078 BTN: RO, {27'b0, btn_sync}.
  - Any other offset reads 32'h0; writes to it are ignored. Writes to SW/BTN are ignored.
- Bus_rdata = is_periph ? peripheral mux : dram_rdata. Purely combinational; zero latency.
- Input sync: sw and button each pass through two flops. Register reads reflect pins 2 cycles later. Reset value 0.
- Timer:
  - Prescale counter runs 0..TMR_DIV-1. TMR increments by 1 when the prescaler wraps, with 32-bit wrap 0xFFFF_FFFF -> 0.
  - A write to TMR loads Bus_wdata and clears the prescaler. Write has priority over a same-cycle increment.
- Display scan FSM:
  - State = digit index idx (3 bits) plus scan counter sc (0..SCAN_DIV-1).
  - sc wraps to 0 at SCAN_DIV-1; idx increments on that wrap, 7 -> 0.
  - dig_en = ~(8'b1 << idx), registered.
  - dig_seg = hex decode of DIG[4*idx+3 : 4*idx], registered, dp always 1 (off).
  - Decode table (hex digit -> dig_seg):
    - 0..3: 0->03, 1->9F, 2->25, 3->0D
    - 4..7: 4->99, 5->49, 6->41, 7->1F
    - 8..B: 8->01, 9->09, A->11, B->C1
    - C..F: C->63, D->85, E->61, F->71
  - A DIG write is visible on the currently lit digit from the next cycle. It does not reset the scan.
- Reset (cpu_rst_n low, asynchronous):
  - DIG=0, TMR=0, LED=0, sync flops=0, prescaler=0, sc=0, idx=0.
  - Outputs: led=0, dig_en=8'hFE, dig_seg=8'h03.
  - Reset asserted mid-scan or mid-count restarts everything from these values on release.
  - dram_we follows Bus_wen combinationally even during reset. The CPU is held in reset alongside, so Bus_wen is 0.

Test Plan:
- Reset, then idle 3 cycles -> led=0, dig_en=FE, dig_seg=03; read 0xFFFF_F020 returns a small count (2..3 with TMR_DIV=1).
- Write 0x00ABCDEF to 0xFFFF_F060, then read it back -> led=24'hABCDEF, Bus_rdata=0x00ABCDEF, dram_we=0 that cycle.
- Write 0x12345678 to 0x0000_0010 -> dram_we=1, dram_addr=14'h004, dram_wdata=0x12345678; a same-address read returns dram_rdata.
- Set sw=24'h5A5A5A at cycle t -> SW read returns 0x005A5A5A from t+2, and 0 at t+1.
- Load TMR=0xFFFF_FFFE with TMR_DIV=1 -> reads FFFF_FFFF, 0, 1 on the following cycles. With write and wrap in the same cycle, the written value wins.
- SCAN_DIV=2, DIG=0x0000F1A0 -> dig_en cycles FE,FD,FB,F7,EF,... every 2 cycles; dig_seg cycles 03,11,9F,71, then 03 for digits 4..7; the sequence wraps after idx=7.
